// File: rtl/div_if.sv
// Divider request/response bundle between pipeline control and div_unit.
//   start  : request pulse, sampled only while busy is low
//   op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b   : dividend / divisor, sampled with start
//   busy   : operation in progress
//   done   : one-cycle pulse, result valid
//   result : quotient or remainder, held until the next done
interface div_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output start, op, a, b, input busy, done, result);
   modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// Sequential RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring radix-2 division, one quotient bit per clock, IDLE -> CALC -> FIN.
// Signed operations divide magnitudes and fix signs in FIN. Divide-by-zero and
// signed overflow fall out of the unsigned iteration, with quotient negation
// suppressed when the divisor is zero.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : div_if slave (start/op/a/b in, busy/done/result out)
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip CALC and finish in two cycles; results are identical in both builds.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic  clk,
   input  logic  reset,
   div_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [CW-1:0]    r_cnt;
   logic             r_is_rem;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_bzero;

   logic             w_signed;
   logic             w_bzero;
   logic [WIDTH-1:0] w_a_abs;
   logic [WIDTH-1:0] w_b_abs;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   // Operand conditioning: magnitudes for signed ops, 0x80000000 maps to itself
   assign w_signed = ~bus.op[0];
   assign w_bzero  = (bus.b == '0);
   assign w_a_abs  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign w_b_abs  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

`ifdef DIV_EARLY_OUT_EN
   logic w_ovf;
   assign w_ovf = w_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
`endif

   // One restoring step; trial[WIDTH] set means the subtraction went negative
   assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
   assign w_trial  = w_rem_sh - {1'b0, r_div};

   // Final sign correction; a zero divisor keeps the all-ones quotient
   assign w_quo_fix = (r_qneg && !r_bzero) ? -r_quo : r_quo;
   assign w_rem_fix = r_rneg ? -r_rem : r_rem;

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_is_rem <= 1'b0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_bzero  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_busy   <= 1'b1;
                  r_is_rem <= bus.op[1];
                  r_qneg   <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  r_rneg   <= w_signed & bus.a[WIDTH-1];
                  r_bzero  <= w_bzero;
                  r_div    <= w_b_abs;
                  r_rem    <= '0;
                  r_quo    <= w_a_abs;
                  r_cnt    <= CW'(WIDTH - 1);
                  r_state  <= CALC;
`ifdef DIV_EARLY_OUT_EN
                  // Preload what the iteration would have produced
                  if (w_bzero || w_ovf) begin
                     r_quo   <= w_bzero ? '1 : w_a_abs;
                     r_rem   <= w_bzero ? w_a_abs : '0;
                     r_state <= FIN;
                  end
`endif
               end
            end
            CALC: begin
               r_rem   <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
               r_quo   <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
               r_cnt   <= r_cnt - CW'(1);
               if (r_cnt == '0) begin
                  r_state <= FIN;
               end
            end
            FIN: begin
               r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;
   localparam int LAT_FULL = 34;   // negedges from start drive to done visible
   localparam int BUSY_FULL = 33;
`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_FAST = 2;
`else
   localparam int LAT_FAST = LAT_FULL;
`endif

   logic clk;
   logic reset;
   int   chk_cnt;
   int   pass_cnt;

   div_if #(.WIDTH(32)) u_if ();

   div_unit #(.WIDTH(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op and wait (bounded) for done; returns at the done negedge
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bcnt);
      @(negedge clk);
      u_if.start = 1'b1; u_if.op = op; u_if.a = a; u_if.b = b;
      @(negedge clk);
      u_if.start = 1'b0;
      lat = 1; bcnt = 0;
      while (!u_if.done && lat < 100) begin
         if (u_if.busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      res = u_if.result;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_cnt++; if (u_if.busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", u_if.busy); else pass_cnt++;
      chk_cnt++; if (u_if.done !== 1'b0) $display("FAIL reset_done got %0b exp 0", u_if.done); else pass_cnt++;
      chk_cnt++; if (u_if.result !== 32'h0) $display("FAIL reset_result got %h exp 0", u_if.result); else pass_cnt++;
   endtask

   task automatic test_divu();
      logic [31:0] res; int lat, bcnt;
      run_op(2'b01, 32'd100, 32'd7, res, lat, bcnt);
      chk_cnt++; if (res !== 32'd14) $display("FAIL divu_result got %h exp %h", res, 32'd14); else pass_cnt++;
      chk_cnt++; if (lat !== LAT_FULL) $display("FAIL divu_latency got %0d exp %0d", lat, LAT_FULL); else pass_cnt++;
      chk_cnt++; if (bcnt !== BUSY_FULL) $display("FAIL divu_busy_cycles got %0d exp %0d", bcnt, BUSY_FULL); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (u_if.done !== 1'b0) $display("FAIL divu_done_width got %0b exp 0", u_if.done); else pass_cnt++;
      run_op(2'b11, 32'd100, 32'd7, res, lat, bcnt);
      chk_cnt++; if (res !== 32'd2) $display("FAIL remu_result got %h exp %h", res, 32'd2); else pass_cnt++;
   endtask

   task automatic test_signed();
      logic [31:0] res; int lat, bcnt;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
      chk_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL rem_neg got %h exp FFFFFFFF", res); else pass_cnt++;
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
      chk_cnt++; if (res !== 32'hFFFF_FFFD) $display("FAIL div_neg got %h exp FFFFFFFD", res); else pass_cnt++;
      run_op(2'b00, 32'd7, 32'hFFFF_FFFE, res, lat, bcnt);
      chk_cnt++; if (res !== 32'hFFFF_FFFD) $display("FAIL div_negdivisor got %h exp FFFFFFFD", res); else pass_cnt++;
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, res, lat, bcnt);
      chk_cnt++; if (res !== 32'd1) $display("FAIL rem_negdivisor got %h exp 1", res); else pass_cnt++;
      run_op(2'b01, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
      chk_cnt++; if (res !== 32'h7FFF_FFFC) $display("FAIL divu_big got %h exp 7FFFFFFC", res); else pass_cnt++;
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
      chk_cnt++; if (res !== 32'd1) $display("FAIL remu_big got %h exp 1", res); else pass_cnt++;
   endtask

   task automatic test_div_zero();
      logic [31:0] res; int lat, bcnt;
      run_op(2'b00, 32'd5, 32'd0, res, lat, bcnt);
      chk_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL div_by0 got %h exp FFFFFFFF", res); else pass_cnt++;
      chk_cnt++; if (lat !== LAT_FAST) $display("FAIL div_by0_latency got %0d exp %0d", lat, LAT_FAST); else pass_cnt++;
      run_op(2'b11, 32'h0000_1234, 32'd0, res, lat, bcnt);
      chk_cnt++; if (res !== 32'h0000_1234) $display("FAIL remu_by0 got %h exp 00001234", res); else pass_cnt++;
      run_op(2'b00, 32'hFFFF_FFFB, 32'd0, res, lat, bcnt);
      chk_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL div_neg_by0 got %h exp FFFFFFFF", res); else pass_cnt++;
      run_op(2'b10, 32'hFFFF_FFFB, 32'd0, res, lat, bcnt);
      chk_cnt++; if (res !== 32'hFFFF_FFFB) $display("FAIL rem_neg_by0 got %h exp FFFFFFFB", res); else pass_cnt++;
      run_op(2'b01, 32'd5, 32'd0, res, lat, bcnt);
      chk_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL divu_by0 got %h exp FFFFFFFF", res); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [31:0] res; int lat, bcnt;
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt);
      chk_cnt++; if (res !== 32'h8000_0000) $display("FAIL div_ovf got %h exp 80000000", res); else pass_cnt++;
      chk_cnt++; if (lat !== LAT_FAST) $display("FAIL div_ovf_latency got %0d exp %0d", lat, LAT_FAST); else pass_cnt++;
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt);
      chk_cnt++; if (res !== 32'h0) $display("FAIL rem_ovf got %h exp 0", res); else pass_cnt++;
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt);
      chk_cnt++; if (res !== 32'h0) $display("FAIL divu_nonovf got %h exp 0", res); else pass_cnt++;
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt);
      chk_cnt++; if (res !== 32'h8000_0000) $display("FAIL remu_nonovf got %h exp 80000000", res); else pass_cnt++;
   endtask

   task automatic test_busy_ignore();
      int lat;
      @(negedge clk);
      u_if.start = 1'b1; u_if.op = 2'b01; u_if.a = 32'd100; u_if.b = 32'd7;
      @(negedge clk);
      u_if.start = 1'b0;
      lat = 1;
      while (!u_if.done && lat < 100) begin
         if (lat == 10) begin
            u_if.start = 1'b1; u_if.op = 2'b00; u_if.a = 32'd1000; u_if.b = 32'd3;
         end else begin
            u_if.start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      u_if.start = 1'b0;
      chk_cnt++; if (u_if.result !== 32'd14) $display("FAIL busy_ignore_result got %h exp %h", u_if.result, 32'd14); else pass_cnt++;
      chk_cnt++; if (lat !== LAT_FULL) $display("FAIL busy_ignore_latency got %0d exp %0d", lat, LAT_FULL); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (u_if.busy !== 1'b0) $display("FAIL busy_ignore_idle got %0b exp 0", u_if.busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] res; int lat, bcnt, held_bad;
      run_op(2'b01, 32'd100, 32'd7, res, lat, bcnt);
      // Start in the done cycle
      u_if.start = 1'b1; u_if.op = 2'b11; u_if.a = 32'd100; u_if.b = 32'd7;
      @(negedge clk);
      u_if.start = 1'b0;
      chk_cnt++; if (u_if.busy !== 1'b1) $display("FAIL b2b_accept got %0b exp 1", u_if.busy); else pass_cnt++;
      lat = 1; held_bad = 0;
      while (!u_if.done && lat < 100) begin
         if (u_if.result !== 32'd14) held_bad++;
         @(negedge clk);
         lat++;
      end
      chk_cnt++; if (held_bad !== 0) $display("FAIL b2b_result_held got %0d bad cycles exp 0", held_bad); else pass_cnt++;
      chk_cnt++; if (u_if.result !== 32'd2) $display("FAIL b2b_second got %h exp %h", u_if.result, 32'd2); else pass_cnt++;
      chk_cnt++; if (lat !== LAT_FULL) $display("FAIL b2b_latency got %0d exp %0d", lat, LAT_FULL); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] res; int lat, bcnt, dn;
      @(negedge clk);
      u_if.start = 1'b1; u_if.op = 2'b01; u_if.a = 32'd100; u_if.b = 32'd7;
      @(negedge clk);
      u_if.start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_cnt++; if (u_if.busy !== 1'b0) $display("FAIL midrst_busy got %0b exp 0", u_if.busy); else pass_cnt++;
      chk_cnt++; if (u_if.done !== 1'b0) $display("FAIL midrst_done got %0b exp 0", u_if.done); else pass_cnt++;
      chk_cnt++; if (u_if.result !== 32'h0) $display("FAIL midrst_result got %h exp 0", u_if.result); else pass_cnt++;
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (u_if.done) dn++;
      end
      chk_cnt++; if (dn !== 0) $display("FAIL midrst_no_done got %0d pulses exp 0", dn); else pass_cnt++;
      run_op(2'b01, 32'd1000, 32'd10, res, lat, bcnt);
      chk_cnt++; if (res !== 32'd100) $display("FAIL midrst_recover got %h exp %h", res, 32'd100); else pass_cnt++;
      chk_cnt++; if (lat !== LAT_FULL) $display("FAIL midrst_latency got %0d exp %0d", lat, LAT_FULL); else pass_cnt++;
   endtask

   initial begin
      chk_cnt = 0; pass_cnt = 0;
      reset = 1'b1;
      u_if.start = 1'b0; u_if.op = 2'b00; u_if.a = '0; u_if.b = '0;
      test_reset();
      test_divu();
      test_signed();
      test_div_zero();
      test_overflow();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
